// File: rtl/aes_pkg.sv
// Shared AES definitions: widths, round count, key-schedule states and GF(2^8) helpers.
package aes_pkg;

  localparam int unsigned AES_NR    = 10;
  localparam int unsigned AES_KEY_W = 128;

  localparam logic [7:0] AES_RCON_INIT = 8'h01;
  localparam logic [7:0] AES_POLY_RED  = 8'h1b;

  typedef enum logic {
    IDLE,
    RUN
  } ks_state_t;

  // Multiply by x in GF(2^8) modulo x^8+x^4+x^3+x+1; also advances Rcon.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? AES_POLY_RED : 8'h00);
  endfunction

  function automatic logic [31:0] rot_word(input logic [31:0] w);
    return {w[23:0], w[31:24]};
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = '0;
    aa = a;
    for (int unsigned i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = xtime(aa);
    end
    return p;
  endfunction

endpackage

// File: rtl/aes_sub_word.sv
// SubWord: applies the S-box independently to each byte of a 32-bit word.
module aes_sub_word (
  input  logic [31:0] w,
  output logic [31:0] y
);

  sbox u_sbox3 (.a(w[31:24]), .y(y[31:24]));
  sbox u_sbox2 (.a(w[23:16]), .y(y[23:16]));
  sbox u_sbox1 (.a(w[15:8]),  .y(y[15:8]));
  sbox u_sbox0 (.a(w[7:0]),   .y(y[7:0]));

endmodule

// File: rtl/sbox.sv
// AES forward S-box: multiplicative inverse in GF(2^8) followed by the affine map.
module sbox
  import aes_pkg::*;
(
  input  logic [7:0] a,
  output logic [7:0] y
);

  logic [7:0] x2, x3, x6, x12, x14, x15, x30, x60, x120, x240, inv;

  // Inverse as a^254 via a fixed addition chain; a=0 maps to 0 naturally.
  always_comb begin
    x2   = gf_mul(a, a);
    x3   = gf_mul(x2, a);
    x6   = gf_mul(x3, x3);
    x12  = gf_mul(x6, x6);
    x14  = gf_mul(x12, x2);
    x15  = gf_mul(x12, x3);
    x30  = gf_mul(x15, x15);
    x60  = gf_mul(x30, x30);
    x120 = gf_mul(x60, x60);
    x240 = gf_mul(x120, x120);
    inv  = gf_mul(x240, x14);
  end

  always_comb begin
    y = inv
      ^ {inv[6:0], inv[7]}
      ^ {inv[5:0], inv[7:6]}
      ^ {inv[4:0], inv[7:5]}
      ^ {inv[3:0], inv[7:4]}
      ^ 8'h63;
  end

endmodule

// File: rtl/aes_key_expand.sv
// Iterative AES-128 key schedule: streams round keys 0..10 over a valid/ready handshake.
module aes_key_expand
  import aes_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [AES_KEY_W-1:0] key_in,
  output logic                 rk_valid,
  input  logic                 rk_ready,
  output logic [AES_KEY_W-1:0] rk_data,
  output logic [3:0]           rk_round,
  output logic                 busy,
  output logic                 done
);

  ks_state_t state;
  logic [7:0]  rcon;
  logic [31:0] w0, w1, w2, w3;
  logic [31:0] sub_out, temp;
  logic [31:0] n0, n1, n2, n3;

  assign {w0, w1, w2, w3} = rk_data;

  aes_sub_word u_sub_word (
    .w (rot_word(w3)),
    .y (sub_out)
  );

  always_comb begin
    temp = sub_out ^ {rcon, 24'h0};
    n0   = w0 ^ temp;
    n1   = w1 ^ n0;
    n2   = w2 ^ n1;
    n3   = w3 ^ n2;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      rk_valid <= 1'b0;
      rk_data  <= '0;
      rk_round <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      rcon     <= AES_RCON_INIT;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            rk_data  <= key_in;
            rk_round <= '0;
            rcon     <= AES_RCON_INIT;
            rk_valid <= 1'b1;
            busy     <= 1'b1;
            state    <= RUN;
          end
        end
        RUN: begin
          // rk_valid is always high here, so rk_ready alone marks a handshake.
          if (rk_ready) begin
            if (rk_round == 4'(AES_NR)) begin
              rk_valid <= 1'b0;
              busy     <= 1'b0;
              done     <= 1'b1;
              state    <= IDLE;
            end else begin
              rk_data  <= {n0, n1, n2, n3};
              rk_round <= rk_round + 4'd1;
              rcon     <= xtime(rcon);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_key_expand.sv
// Scoreboard bench for aes_key_expand with an independent key-schedule reference model.
module tb_aes_key_expand;

  logic         clk = 1'b0;
  logic         rst, start, rk_ready, rk_valid, busy, done;
  logic [127:0] key_in, rk_data;
  logic [3:0]   rk_round;

  aes_key_expand dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .key_in   (key_in),
    .rk_valid (rk_valid),
    .rk_ready (rk_ready),
    .rk_data  (rk_data),
    .rk_round (rk_round),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] ZERO_KEY = '0;
  localparam logic [127:0] ALT_KEY  = 128'h000102030405060708090a0b0c0d0e0f;

  typedef struct {
    logic [127:0] key;
    logic [3:0]   round;
    logic [127:0] data;
  } exp_t;

  exp_t sbq[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   ready_mode = 0;

  task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  function automatic logic [7:0] ref_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x, y;
    logic hi;
    p = '0; x = a; y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      hi = x[7];
      x  = x << 1;
      if (hi) x = x ^ 8'h1b;
      y = y >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] ref_sbox(input logic [7:0] x);
    logic [7:0] inv, c, s;
    inv = '0; c = 8'h63;
    for (int y = 1; y < 256; y++)
      if (ref_mul(x, 8'(y)) == 8'h01) inv = 8'(y);
    for (int i = 0; i < 8; i++)
      s[i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8] ^ inv[(i+6)%8] ^ inv[(i+7)%8] ^ c[i];
    return s;
  endfunction

  task automatic push_schedule(input logic [127:0] key);
    logic [31:0] w [44];
    logic [7:0]  rc [10];
    logic [31:0] t;
    exp_t e;
    rc = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {ref_sbox(t[31:24]), ref_sbox(t[23:16]), ref_sbox(t[15:8]), ref_sbox(t[7:0])};
        t[31:24] = t[31:24] ^ rc[i/4-1];
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r <= 10; r++) begin
      e.key   = key;
      e.round = 4'(r);
      e.data  = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
      sbq.push_back(e);
    end
  endtask

  // Ready generator: 0 = low, 1 = high, 2 = random
  always @(posedge clk) begin
    #1;
    case (ready_mode)
      1:       rk_ready = 1'b1;
      2:       rk_ready = 1'($urandom_range(0, 1));
      default: rk_ready = 1'b0;
    endcase
  end

  logic         expect_done = 1'b0;
  logic         post_rst = 1'b0;
  logic         stall = 1'b0;
  logic [127:0] prev_data;
  logic [3:0]   prev_round;

  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      sbq.delete();
      expect_done = 1'b0;
      stall       = 1'b0;
      post_rst    = 1'b1;
    end else begin
      if (post_rst) begin
        check("rst_valid", rk_valid, 0);
        check("rst_busy",  busy, 0);
        check("rst_round", rk_round, 0);
        check("rst_data",  rk_data, 0);
        post_rst = 1'b0;
      end
      check("done", done, expect_done);
      if (expect_done) begin
        check("done_busy",  busy, 0);
        check("done_valid", rk_valid, 0);
        expect_done = 1'b0;
      end
      if (stall) begin
        check("stall_data",  rk_data, prev_data);
        check("stall_round", rk_round, prev_round);
      end
      if (rk_valid && rk_ready) begin
        if (sbq.size() == 0) begin
          check("sb_empty", 1, 0);
        end else begin
          e = sbq.pop_front();
          check("rk_round", rk_round, e.round);
          check("rk_data",  rk_data, e.data);
          if (e.key == FIPS_KEY && e.round == 4'd1)
            check("fips_r1", rk_data, 128'ha0fafe1788542cb123a339392a6c7605);
          if (e.key == FIPS_KEY && e.round == 4'd2)
            check("fips_r2", rk_data, 128'hf2c295f27a96b9435935807a7359f67f);
          if (e.key == FIPS_KEY && e.round == 4'd10)
            check("fips_r10", rk_data, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
          if (e.key == ZERO_KEY && e.round == 4'd1)
            check("zero_r1", rk_data, 128'h62636363626363636263636362636363);
          if (e.key == ZERO_KEY && e.round == 4'd10)
            check("zero_r10", rk_data, 128'hb4ef5bcb3e92e21123e951cf6f8f188e);
          if (e.round == 4'd10) expect_done = 1'b1;
        end
      end
      stall      = rk_valid && !rk_ready;
      prev_data  = rk_data;
      prev_round = rk_round;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [127:0] key, input bit expect_accept);
    start  = 1'b1;
    key_in = key;
    if (expect_accept) push_schedule(key);
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    for (int i = 0; i < 400; i++) begin
      tick();
      lat++;
      if (done) return;
    end
    check("timeout_done", 0, 1);
  endtask

  task automatic wait_round(input logic [3:0] r);
    for (int i = 0; i < 400; i++) begin
      if (rk_valid && rk_round == r) return;
      tick();
    end
    check("timeout_round", 0, 1);
  endtask

  initial begin
    int lat;
    rst = 1'b1; start = 1'b0; key_in = '0; rk_ready = 1'b0;
    tick(); tick();
    rst = 1'b0;
    ready_mode = 1;
    repeat (4) tick();
    check("idle_ready_ignored", rk_valid, 0);

    // FIPS key, ready held high; done 12 cycles after start
    do_start(FIPS_KEY, 1);
    wait_done(lat);
    check("fips_done_lat", lat + 1, 12);
    tick();

    do_start(ZERO_KEY, 1);
    wait_done(lat);
    tick();

    ready_mode = 2;
    do_start(FIPS_KEY, 1);
    wait_done(lat);
    tick();

    // start mid-schedule must be ignored
    ready_mode = 1;
    do_start(FIPS_KEY, 1);
    wait_round(4);
    do_start(ALT_KEY, 0);
    wait_done(lat);
    tick();

    // reset aborts the schedule at round 6
    do_start(FIPS_KEY, 1);
    wait_round(6);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    check("abort_no_done", done, 0);
    do_start(FIPS_KEY, 1);
    wait_done(lat);

    // start in the done cycle launches the next schedule immediately
    do_start(ZERO_KEY, 1);
    check("b2b_valid", rk_valid, 1);
    check("b2b_round", rk_round, 0);
    check("b2b_data",  rk_data, ZERO_KEY);
    wait_done(lat);
    repeat (3) tick();
    check("sb_drain", sbq.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
